// File: rtl/mips_cpu_bus_mem.sv
// Avalon-style word memory slave for mips_cpu_bus with waitrequest stalls on every transfer.
// Defining MEM_RANDOM_WAIT_EN replaces the fixed WAIT_CYCLES stall with a per-transfer LFSR length.
module mips_cpu_bus_mem #(
    parameter string       INIT_FILE   = "",
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        byteenable,
    input  logic [31:0]       writedata,
    output logic              waitrequest,
    output logic [31:0]       readdata
);
    localparam int unsigned Depth = 2 ** (ADDR_W - 2);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-3:0]   addr_q;
    logic [3:0]          be_q;
    logic [31:0]         wdata_q;
    logic                wr_q;
    logic [31:0]         readdata_q;
    logic [3:0]          stall_len;
    logic                req, start, done;
    logic [31:0]         mem [Depth];

    logic unused_addr;
    assign unused_addr = ^addr[1:0];

    initial begin
        for (int i = 0; i < int'(Depth); i++) begin
            mem[i] = 32'h0;
        end
    end

    assign req   = read | write;
    assign start = (state_q == StIdle) && req;
    assign done  = (state_q == StBusy) && (cnt_q == stall_len);

`ifdef MEM_RANDOM_WAIT_EN
    logic [7:0] lfsr_q;
    logic [3:0] wait_q;
    logic [3:0] unused_wait;
    assign unused_wait = 4'(WAIT_CYCLES);

    // Stall length is taken from the LFSR value before this start edge advances it.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
            wait_q <= 4'd1;
        end else if (start) begin
            wait_q <= {1'b0, lfsr_q[2:0]} + 4'd1;
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end
    assign stall_len = wait_q;
`else
    assign stall_len = 4'(WAIT_CYCLES);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StBusy;
                    cnt_d   = 4'd1;
                end
            end
            StBusy: begin
                if (cnt_q == stall_len) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        waitrequest = 1'b1;
        if (!rst) begin
            waitrequest = (state_q == StIdle) ? req : (cnt_q != stall_len);
        end
    end

    // Request fields are frozen at start; bus changes during the stall are ignored.
    always_ff @(posedge clk) begin
        if (start) begin
            addr_q  <= addr[ADDR_W-1:2];
            be_q    <= byteenable;
            wdata_q <= writedata;
            wr_q    <= write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            readdata_q <= 32'h0;
        end else if (start) begin
            readdata_q <= mem[addr[ADDR_W-1:2]];
        end
    end
    assign readdata = readdata_q;

    always_ff @(posedge clk) begin
        if (!rst && done && wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && start && read && write) begin
            $error("mips_cpu_bus_mem: read and write asserted together, treated as write");
        end
    end
`endif

endmodule

// File: tb/tb_mips_cpu_bus_mem.sv
// Bench for mips_cpu_bus_mem: three instances with stall lengths 1..3 share one vector table.
// Expected stall lengths follow an LFSR reference model when MEM_RANDOM_WAIT_EN is defined.
module tb_mips_cpu_bus_mem;
    localparam int NDEV = 3;

    logic        clk = 1'b0;
    logic        rst         [NDEV];
    logic        read        [NDEV];
    logic        write       [NDEV];
    logic [15:0] addr        [NDEV];
    logic [3:0]  byteenable  [NDEV];
    logic [31:0] writedata   [NDEV];
    logic        waitrequest [NDEV];
    logic [31:0] readdata    [NDEV];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDEV; g++) begin : g_dut
        mips_cpu_bus_mem #(
            .INIT_FILE   (""),
            .ADDR_W      (16),
            .WAIT_CYCLES (g + 1)
        ) u_dut (
            .clk         (clk),
            .rst         (rst[g]),
            .read        (read[g]),
            .write       (write[g]),
            .addr        (addr[g]),
            .byteenable  (byteenable[g]),
            .writedata   (writedata[g]),
            .waitrequest (waitrequest[g]),
            .readdata    (readdata[g])
        );
    end

    typedef struct {
        logic        wr;
        logic [15:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        tog;
        logic        drop;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_rd_q[$];
    int unsigned exp_w_q[$];
    int          checks = 0;
    int          errors = 0;

`ifdef MEM_RANDOM_WAIT_EN
    logic [7:0] lfsr_m [NDEV];
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset(input int d);
`ifdef MEM_RANDOM_WAIT_EN
        lfsr_m[d] = 8'hA5;
`else
        if (d < 0) $display("bad device index");
`endif
    endtask

    // Stall length of the next transfer on device d; advances the reference LFSR.
    task automatic model_w(input int d, output int unsigned w);
`ifdef MEM_RANDOM_WAIT_EN
        w = 32'(lfsr_m[d] & 8'h07) + 1;
        lfsr_m[d] = {lfsr_m[d][6:0], ^(lfsr_m[d] & 8'hB8)};
`else
        w = 32'(d) + 1;
`endif
    endtask

    // Called just after a rising edge; returns just after the edge that ends the transfer.
    task automatic do_xfer(input int d, input logic wr, input logic [15:0] a, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] rd, input logic tog,
                           input logic drop);
        int unsigned w;
        int unsigned stalls;
        int unsigned w_exp;
        logic [31:0] rd_exp;
        model_w(d, w);
        exp_w_q.push_back(w);
        if (!wr) exp_rd_q.push_back(rd);
        read[d]       = !wr;
        write[d]      = wr;
        addr[d]       = a;
        byteenable[d] = be;
        writedata[d]  = wd;
        stalls        = 0;
        @(negedge clk);
        while (waitrequest[d] && stalls < 40) begin
            stalls++;
            @(posedge clk);
            #1;
            if (drop) begin
                read[d]  = 1'b0;
                write[d] = 1'b0;
            end
            if (tog) begin
                addr[d]       = 16'($urandom);
                writedata[d]  = $urandom;
                byteenable[d] = 4'($urandom);
            end
            @(negedge clk);
        end
        w_exp = exp_w_q.pop_front();
        check($sformatf("stall_len dev%0d addr %h", d, a), 32'(stalls), 32'(w_exp));
        if (!wr) begin
            rd_exp = exp_rd_q.pop_front();
            check($sformatf("readdata dev%0d addr %h", d, a), readdata[d], rd_exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle(input int d);
        read[d]  = 1'b0;
        write[d] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Reset in the cycle after a write starts must discard the write and clear readdata.
    task automatic reset_abort(input int d);
        int unsigned w;
        model_w(d, w);
        write[d]      = 1'b1;
        read[d]       = 1'b0;
        addr[d]       = 16'h0020;
        byteenable[d] = 4'hF;
        writedata[d]  = 32'hCAFEF00D;
        @(negedge clk);
        check($sformatf("abort start wait dev%0d", d), 32'(waitrequest[d]), 32'd1);
        @(posedge clk);
        #1;
        rst[d] = 1'b1;
        @(negedge clk);
        check($sformatf("abort rst wait dev%0d", d), 32'(waitrequest[d]), 32'd1);
        @(posedge clk);
        #1;
        write[d] = 1'b0;
        @(negedge clk);
        check($sformatf("abort rst hold wait dev%0d", d), 32'(waitrequest[d]), 32'd1);
        @(posedge clk);
        #1;
        rst[d] = 1'b0;
        model_reset(d);
        @(negedge clk);
        check($sformatf("post rst wait dev%0d", d), 32'(waitrequest[d]), 32'd0);
        check($sformatf("post rst readdata dev%0d", d), readdata[d], 32'h0);
        @(posedge clk);
        #1;
        do_xfer(d, 1'b0, 16'h0020, 4'h0, 32'h0, 32'h55AA55AA, 1'b0, 1'b0);
        go_idle(d);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < NDEV; d++) begin
            rst[d]         = 1'b1;
            read[d]        = 1'b0;
            write[d]       = 1'b0;
            addr[d]        = 16'h0;
            byteenable[d]  = 4'h0;
            writedata[d]   = 32'h0;
        end

        vecs.push_back('{1'b0, 16'h0000, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0});
        vecs.push_back('{1'b1, 16'h0000, 4'hF, 32'h3C021234, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{1'b0, 16'h0000, 4'h0, 32'h0,        32'h3C021234, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 16'h0010, 4'h5, 32'hAABBCCDD, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{1'b0, 16'h0010, 4'h0, 32'h0,        32'h00BB00DD, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 16'h0010, 4'hA, 32'h11223344, 32'h0,        1'b1, 1'b0});
        vecs.push_back('{1'b0, 16'h0012, 4'h0, 32'h0,        32'h11BB33DD, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 16'h0014, 4'h0, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{1'b0, 16'h0014, 4'hF, 32'h0,        32'h0,        1'b0, 1'b0});
        vecs.push_back('{1'b1, 16'hFFFC, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1});
        vecs.push_back('{1'b0, 16'hFFFF, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 16'h0004, 4'h8, 32'h12345678, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{1'b0, 16'h0004, 4'h0, 32'h0,        32'h12000000, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 16'h0020, 4'hF, 32'h55AA55AA, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{1'b0, 16'h0020, 4'h0, 32'h0,        32'h55AA55AA, 1'b0, 1'b0});

        @(posedge clk);
        #1;
        @(negedge clk);
        for (int d = 0; d < NDEV; d++) begin
            check($sformatf("in-reset wait dev%0d", d), 32'(waitrequest[d]), 32'd1);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < NDEV; d++) begin
            rst[d] = 1'b0;
            model_reset(d);
        end
        @(negedge clk);
        for (int d = 0; d < NDEV; d++) begin
            check($sformatf("reset wait dev%0d", d), 32'(waitrequest[d]), 32'd0);
            check($sformatf("reset readdata dev%0d", d), readdata[d], 32'h0);
        end
        @(posedge clk);
        #1;

        // Table runs back-to-back so every transfer starts the cycle after the previous one ends.
        for (int d = 0; d < NDEV; d++) begin
            for (int i = 0; i < vecs.size(); i++) begin
                do_xfer(d, vecs[i].wr, vecs[i].a, vecs[i].be, vecs[i].wd, vecs[i].rd,
                        vecs[i].tog, vecs[i].drop);
            end
            go_idle(d);
        end

        for (int d = 0; d < NDEV; d++) begin
            reset_abort(d);
        end

        for (int i = 0; i < 64; i++) begin
            if (i % 2 == 0) begin
                do_xfer(0, 1'b0, 16'h0000, 4'h0, 32'h0, 32'h3C021234, 1'b0, 1'b0);
            end else begin
                do_xfer(0, 1'b0, 16'h0010, 4'h0, 32'h0, 32'h11BB33DD, 1'b0, 1'b0);
            end
        end
        go_idle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
